// File: rtl/johnson_decoder.sv
// Johnson (twisted-ring) code receiver: decodes N-bit Johnson samples to a phase index,
// flags illegal words and sequence breaks, tracks lock and a saturating error count.
module johnson_decoder #(
    parameter int N          = 4,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2,
    parameter int ERR_W      = 8,
    parameter int IDX_W      = $clog2(2 * N)
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [N-1:0]     j_in,
    input  logic             j_valid,
    input  logic             err_clr,
    output logic [IDX_W-1:0] idx_out,
    output logic             idx_valid,
    output logic             illegal,
    output logic             seq_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int POP_W  = $clog2(N + 1);
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {
        S_UNLOCKED,
        S_ACQUIRE,
        S_LOCKED
    } state_t;

    state_t            r_state;
    logic [RUN_W-1:0]  r_run;
    logic [MISS_W-1:0] r_miss;
    logic [IDX_W-1:0]  r_prev;

    logic [POP_W-1:0]  w_pop;
    logic [POP_W-1:0]  w_trans;
    logic              w_legal;
    logic [IDX_W-1:0]  w_idx;
    logic [IDX_W-1:0]  w_next_exp;
    logic              w_in_seq;
    logic              w_bad_locked;

    always_comb begin
        w_pop   = '0;
        w_trans = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_pop = w_pop + POP_W'(j_in[i]);
        end
        for (int unsigned i = 0; i + 1 < N; i++) begin
            w_trans = w_trans + POP_W'(j_in[i] ^ j_in[i+1]);
        end
        w_legal = (w_trans <= POP_W'(1));
        // Upper half of the ring counts down from 2N as the low zeros grow.
        w_idx = j_in[N-1] ? (IDX_W'(2 * N) - IDX_W'(w_pop)) : IDX_W'(w_pop);
        w_next_exp = (r_prev == IDX_W'(2 * N - 1)) ? '0 : (r_prev + IDX_W'(1));
        w_in_seq = (w_idx == w_next_exp);
        w_bad_locked = (r_state == S_LOCKED) && j_valid && (!w_legal || !w_in_seq);
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_state   <= S_UNLOCKED;
            r_run     <= '0;
            r_miss    <= '0;
            r_prev    <= '0;
            idx_out   <= '0;
            idx_valid <= 1'b0;
            illegal   <= 1'b0;
            seq_err   <= 1'b0;
            locked    <= 1'b0;
            err_cnt   <= '0;
        end else begin
            idx_valid <= 1'b0;
            illegal   <= 1'b0;
            seq_err   <= w_bad_locked;

            if (j_valid) begin
                if (w_legal) begin
                    idx_out   <= w_idx;
                    idx_valid <= 1'b1;
                    r_prev    <= w_idx;
                end else begin
                    illegal <= 1'b1;
                end

                case (r_state)
                    S_UNLOCKED: begin
                        if (w_legal) begin
                            if (LOCK_CNT == 1) begin
                                r_state <= S_LOCKED;
                                locked  <= 1'b1;
                                r_run   <= '0;
                                r_miss  <= '0;
                            end else begin
                                r_state <= S_ACQUIRE;
                                r_run   <= RUN_W'(1);
                            end
                        end
                    end
                    S_ACQUIRE: begin
                        if (!w_legal) begin
                            r_state <= S_UNLOCKED;
                            r_run   <= '0;
                        end else if (!w_in_seq) begin
                            r_run <= RUN_W'(1);
                        end else if (r_run == RUN_W'(LOCK_CNT - 1)) begin
                            r_state <= S_LOCKED;
                            locked  <= 1'b1;
                            r_run   <= '0;
                            r_miss  <= '0;
                        end else begin
                            r_run <= r_run + RUN_W'(1);
                        end
                    end
                    S_LOCKED: begin
                        if (!w_bad_locked) begin
                            r_miss <= '0;
                        end else if (r_miss == MISS_W'(UNLOCK_CNT - 1)) begin
                            r_state <= S_UNLOCKED;
                            locked  <= 1'b0;
                            r_miss  <= '0;
                            r_run   <= '0;
                        end else begin
                            r_miss <= r_miss + MISS_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_UNLOCKED;
                        locked  <= 1'b0;
                    end
                endcase
            end

            // Clear wins over a coincident error; that error is dropped from the count.
            if (err_clr) begin
                err_cnt <= '0;
            end else if (w_bad_locked && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder: a code-table/run-length reference model checked
// every cycle against two instances (8-bit and 2-bit error counters), plus literal pins.
module tb_johnson_decoder;

    localparam int N   = 4;
    localparam int LCK = 3;
    localparam int ULK = 2;

    logic       clk = 1'b0;
    logic       rst_ = 1'b1;
    logic [3:0] j_in = 4'b0000;
    logic       j_valid = 1'b0;
    logic       err_clr = 1'b0;

    logic [2:0] a_idx, b_idx;
    logic       a_val, b_val, a_ill, b_ill, a_seq, b_seq, a_lck, b_lck;
    logic [7:0] a_err;
    logic [1:0] b_err;

    int n_chk  = 0;
    int n_fail = 0;

    johnson_decoder #(.N(N), .LOCK_CNT(LCK), .UNLOCK_CNT(ULK), .ERR_W(8)) u_dut8 (
        .clk(clk), .rst_(rst_), .j_in(j_in), .j_valid(j_valid), .err_clr(err_clr),
        .idx_out(a_idx), .idx_valid(a_val), .illegal(a_ill), .seq_err(a_seq),
        .locked(a_lck), .err_cnt(a_err)
    );

    johnson_decoder #(.N(N), .LOCK_CNT(LCK), .UNLOCK_CNT(ULK), .ERR_W(2)) u_dut2 (
        .clk(clk), .rst_(rst_), .j_in(j_in), .j_valid(j_valid), .err_clr(err_clr),
        .idx_out(b_idx), .idx_valid(b_val), .illegal(b_ill), .seq_err(b_seq),
        .locked(b_lck), .err_cnt(b_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: look the sample up in an explicitly built table of the 2N ring words.
    function automatic int jdec(input logic [3:0] c);
        logic [3:0] w;
        for (int k = 0; k < 2 * N; k++) begin
            if (k <= N) w = 4'((1 << k) - 1);
            else        w = 4'(15 & ~((1 << (k - N)) - 1));
            if (w == c) return k;
        end
        return -1;
    endfunction

    bit m_ok = 0;
    int e_idx, e_val, e_ill, e_seq, e_lck, e_err8, e_err2;
    int m_prev, m_run, m_miss;

    always @(posedge clk) begin
        int k;
        bit insq, bad;
        if (rst_) begin
            m_ok = 1;
            e_idx = 0; e_val = 0; e_ill = 0; e_seq = 0; e_lck = 0; e_err8 = 0; e_err2 = 0;
            m_prev = 0; m_run = 0; m_miss = 0;
        end else begin
            e_val = 0; e_ill = 0; e_seq = 0;
            if (j_valid) begin
                k = jdec(j_in);
                insq = (k >= 0) && (k == (m_prev + 1) % (2 * N));
                if (k >= 0) begin
                    e_idx = k; e_val = 1; m_prev = k;
                end else begin
                    e_ill = 1;
                end
                if (e_lck != 0) begin
                    bad = (k < 0) || !insq;
                    if (bad) begin
                        e_seq = 1;
                        m_miss++;
                        if (m_miss >= ULK) begin
                            e_lck = 0; m_miss = 0; m_run = 0;
                        end
                    end else begin
                        m_miss = 0;
                    end
                end else begin
                    if (k < 0)                    m_run = 0;
                    else if (m_run > 0 && insq)   m_run++;
                    else                          m_run = 1;
                    if (m_run >= LCK) begin
                        e_lck = 1; m_run = 0; m_miss = 0;
                    end
                end
            end
            if (err_clr) begin
                e_err8 = 0; e_err2 = 0;
            end else if (e_seq != 0) begin
                if (e_err8 < 255) e_err8++;
                if (e_err2 < 3)   e_err2++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("idx_out",   a_idx, e_idx);
            chk("idx_valid", a_val, e_val);
            chk("illegal",   a_ill, e_ill);
            chk("seq_err",   a_seq, e_seq);
            chk("locked",    a_lck, e_lck);
            chk("err_cnt8",  a_err, e_err8);
            chk("idx_out2",  b_idx, e_idx);
            chk("locked2",   b_lck, e_lck);
            chk("seq_err2",  b_seq, e_seq);
            chk("err_cnt2",  b_err, e_err2);
        end
    end

    task automatic step(input logic [3:0] j, input logic v, input logic clr, input logic r);
        @(negedge clk);
        j_in = j; j_valid = v; err_clr = clr; rst_ = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with a legal sample present: it must be ignored.
        step(4'b0011, 1, 0, 1);
        chk("rst_idx", a_idx, 0);
        chk("rst_val", a_val, 0);
        chk("rst_lck", a_lck, 0);
        chk("rst_err", a_err, 0);

        step(4'b0000, 1, 0, 0);
        chk("acq0_idx", a_idx, 0);
        chk("acq0_val", a_val, 1);
        step(4'b0001, 1, 0, 0);
        chk("acq1_idx", a_idx, 1);
        chk("acq1_lck", a_lck, 0);
        step(4'b0011, 1, 0, 0);
        chk("acq2_idx", a_idx, 2);
        chk("lock1",    a_lck, 1);
        chk("lock1_err", a_err, 0);

        step(4'b0111, 1, 0, 0);
        step(4'b1111, 1, 0, 0);
        chk("idx4", a_idx, 4);
        step(4'b1110, 1, 0, 0);
        step(4'b1100, 1, 0, 0);
        step(4'b1000, 1, 0, 0);
        chk("idx7", a_idx, 7);
        step(4'b0000, 1, 0, 0);
        chk("wrap_idx", a_idx, 0);
        chk("wrap_seq", a_seq, 0);
        chk("wrap_lck", a_lck, 1);

        step(4'b0101, 1, 0, 0);
        chk("bad_ill", a_ill, 1);
        chk("bad_seq", a_seq, 1);
        chk("bad_val", a_val, 0);
        chk("bad_idx_hold", a_idx, 0);
        chk("bad_err", a_err, 1);
        chk("bad_lck", a_lck, 1);
        step(4'b0001, 1, 0, 0);
        chk("resume_seq", a_seq, 0);
        step(4'b0101, 1, 0, 0);
        step(4'b0101, 1, 0, 0);
        chk("drop_err", a_err, 3);
        chk("drop_lck", a_lck, 0);

        // Reacquire with a skip: the run restarts at 0111.
        step(4'b0000, 1, 0, 0);
        step(4'b0001, 1, 0, 0);
        step(4'b0111, 1, 0, 0);
        chk("skip_idx", a_idx, 3);
        chk("skip_seq", a_seq, 0);
        step(4'b1111, 1, 0, 0);
        chk("skip_lck", a_lck, 0);
        step(4'b1110, 1, 0, 0);
        chk("relock", a_lck, 1);

        step(4'b1110, 0, 1, 0);
        chk("clr_err8", a_err, 0);
        chk("clr_err2", b_err, 0);
        step(4'b0101, 1, 0, 0); step(4'b1100, 1, 0, 0);
        step(4'b0101, 1, 0, 0); step(4'b1000, 1, 0, 0);
        step(4'b0101, 1, 0, 0); step(4'b0000, 1, 0, 0);
        step(4'b0101, 1, 0, 0); step(4'b0001, 1, 0, 0);
        step(4'b0101, 1, 0, 0); step(4'b0011, 1, 0, 0);
        chk("sat_err8", a_err, 5);
        chk("sat_err2", b_err, 3);
        chk("sat_lck",  b_lck, 1);

        step(4'b0101, 1, 1, 0);
        chk("clrpri_err2", b_err, 0);
        chk("clrpri_err8", a_err, 0);
        chk("clrpri_seq",  b_seq, 1);
        step(4'b0111, 1, 0, 0);

        step(4'b0101, 1, 0, 0); step(4'b1111, 1, 0, 0);
        step(4'b0101, 1, 0, 0); step(4'b1110, 1, 0, 0);
        chk("pre_rst_err", a_err, 2);
        chk("pre_rst_lck", a_lck, 1);
        step(4'b1100, 1, 0, 1);
        chk("mid_rst_lck", a_lck, 0);
        chk("mid_rst_err", a_err, 0);
        chk("mid_rst_idx", a_idx, 0);
        step(4'b1100, 1, 0, 0);
        step(4'b1000, 1, 0, 0);
        step(4'b0000, 1, 0, 0);
        chk("post_rst_lck", a_lck, 1);

        step(4'b0000, 1, 0, 0);
        chk("held_seq", a_seq, 1);
        chk("held_err", a_err, 1);
        step(4'b0101, 0, 0, 0);
        chk("idle_val", a_val, 0);
        chk("idle_ill", a_ill, 0);
        chk("idle_idx", a_idx, 0);
        step(4'b0000, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
